// File: rtl/scene_write_arbiter.sv
// Round-robin scene arbiter: locks one producer per scene, truncates scenes longer than MAX_BEATS.
// Optional per-producer completed-scene counters are enabled with `define SCENE_ARB_STATS_EN.
module scene_write_arbiter #(
  parameter int REQ_COUNT = 2,
  parameter int MAX_BEATS = 50,
  parameter int DATA_W    = 64,
  parameter int META_W    = 8,
  parameter int LAST_BIT  = 0,
  localparam int GW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1,
  localparam int BW = $clog2(MAX_BEATS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_COUNT-1:0]        req_valid,
  output logic [REQ_COUNT-1:0]        req_ready,
  input  logic [REQ_COUNT*DATA_W-1:0] req_data,
  input  logic [REQ_COUNT*META_W-1:0] req_metadata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [META_W-1:0]           out_metadata,
  output logic [GW-1:0]               grant_idx,
  output logic                        busy,
  output logic                        overflow
`ifdef SCENE_ARB_STATS_EN
  ,
  output logic [REQ_COUNT*16-1:0]     scene_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOCKED, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          overflow_q, overflow_d;

  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic [META_W-1:0] sel_meta;
  logic              sel_last;
  logic              at_cap;
  logic [GW-1:0]     next_ptr;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [GW:0]   cand_sum;
  logic [GW-1:0] cand_idx;

  assign sel_valid = req_valid[grant_q];
  assign sel_data  = req_data[grant_q*DATA_W +: DATA_W];
  assign sel_meta  = req_metadata[grant_q*META_W +: META_W];
  assign sel_last  = sel_meta[LAST_BIT];
  assign at_cap    = (beat_cnt_q == BW'(MAX_BEATS - 1));
  // Explicit wrap so non-power-of-two producer counts rotate correctly.
  assign next_ptr  = (grant_q == GW'(REQ_COUNT - 1)) ? '0 : grant_q + 1'b1;

  // First requesting producer at or after rr_ptr, wrapping at REQ_COUNT.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand_idx   = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (cand_sum >= (GW+1)'(REQ_COUNT))
        cand_sum = cand_sum - (GW+1)'(REQ_COUNT);
      cand_idx = cand_sum[GW-1:0];
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (sel_valid && out_ready) begin
          if (sel_last) begin
            beat_cnt_d = '0;
            rr_ptr_d   = next_ptr;
            state_d    = IDLE;
          end else if (at_cap) begin
            // Downstream slot is full: close the scene here and swallow the remainder.
            beat_cnt_d = '0;
            overflow_d = 1'b1;
            state_d    = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (sel_valid && sel_last) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid    = 1'b0;
    req_ready    = '0;
    out_data     = sel_data;
    out_metadata = sel_meta;
    case (state_q)
      LOCKED: begin
        out_valid          = sel_valid;
        req_ready[grant_q] = out_ready;
        if (at_cap) out_metadata[LAST_BIT] = 1'b1;
      end
      DRAIN: req_ready[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);
  assign overflow  = overflow_q;

`ifdef SCENE_ARB_STATS_EN
  logic scene_done;

  // A truncated scene is counted at its forced-last beat, not again at the end of the drain.
  assign scene_done = (state_q == LOCKED) && sel_valid && out_ready && (sel_last || at_cap);

  for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_stats
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_q <= '0;
      else if (scene_done && (grant_q == GW'(gi)) && (cnt_q != 16'hFFFF))
        cnt_q <= cnt_q + 16'd1;
    end
    assign scene_count[gi*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_scene_write_arbiter.sv
// Scoreboard bench for scene_write_arbiter: directed scenes per producer, monitor checks forwarded beats.
// Stats checks run only when SCENE_ARB_STATS_EN is defined.
module tb_scene_write_arbiter;
  localparam int RC = 2;
  localparam int MB = 4;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RC-1:0] req_valid;
  logic [RC-1:0] req_ready;
  logic [RC*DW-1:0] req_data;
  logic [RC*MW-1:0] req_metadata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [MW-1:0] out_metadata;
  logic [0:0]    grant_idx;
  logic          busy;
  logic          overflow;
`ifdef SCENE_ARB_STATS_EN
  logic [RC*16-1:0] scene_count;
`endif

  scene_write_arbiter #(.REQ_COUNT(RC), .MAX_BEATS(MB), .DATA_W(DW), .META_W(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_metadata(req_metadata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_metadata(out_metadata),
    .grant_idx(grant_idx), .busy(busy), .overflow(overflow)
`ifdef SCENE_ARB_STATS_EN
    , .scene_count(scene_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic [MW-1:0] meta; int gap; } beat_t;
  typedef struct { int grant; logic [DW-1:0] data; logic [MW-1:0] meta; bit idle_after; } exp_t;

  beat_t src0_q[$];
  beat_t src1_q[$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;
  bit hold_out_low = 1'b0;
  int stall_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scene of n beats; meta = {beat index tag, last}; optional valid gap before beat gap_at.
  task automatic push_scene(input int p, input int base, input int n, input int gap_at, input int gap_len);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = DW'(base + k);
      b.meta = {3'(k), (k == n - 1)};
      b.gap  = (k == gap_at) ? gap_len : 0;
      if (p == 0) src0_q.push_back(b); else src1_q.push_back(b);
    end
  endtask

  task automatic expect_scene(input int p, input int base, input int n, input bit truncated);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.grant = p;
      e.data  = DW'(base + k);
      e.meta  = {3'(k), (k == n - 1)};
      e.idle_after = !truncated;
      exp_q.push_back(e);
      $display("expect p%0d data=%0h meta=%0h", p, e.data, e.meta);
    end
  endtask

  task automatic wait_grant(input int p);
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge clk); #2;
      if (busy && grant_idx == 1'(p)) ok = 1'b1;
    end
    if (!ok) begin errors++; checks++; $display("FAIL grant_timeout p%0d", p); end
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && src0_q.size() == 0 && src1_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL drain_timeout %s exp_left=%0d src0=%0d src1=%0d", name, exp_q.size(), src0_q.size(), src1_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  // Producer/sink driver: pops accepted beats and presents queue heads after each edge.
  initial begin
    logic [RC-1:0] fire;
    beat_t b;
    req_valid = '0; req_data = '0; req_metadata = '0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk); #1;
      if (fire[0] && src0_q.size() > 0) void'(src0_q.pop_front());
      if (fire[1] && src1_q.size() > 0) void'(src1_q.pop_front());
      req_valid[0] = 1'b0;
      if (src0_q.size() > 0) begin
        b = src0_q.pop_front();
        if (b.gap > 0) begin b.gap--; end
        else begin req_valid[0] = 1'b1; req_data[DW-1:0] = b.data; req_metadata[MW-1:0] = b.meta; end
        src0_q.push_front(b);
      end
      req_valid[1] = 1'b0;
      if (src1_q.size() > 0) begin
        b = src1_q.pop_front();
        if (b.gap > 0) begin b.gap--; end
        else begin req_valid[1] = 1'b1; req_data[2*DW-1:DW] = b.data; req_metadata[2*MW-1:MW] = b.meta; end
        src1_q.push_front(b);
      end
      out_ready = !(hold_out_low || stall_out > 0);
      if (stall_out > 0) stall_out--;
    end
  end

  // Monitor: every forwarded beat is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    bit chk_pending = 1'b0;
    bit chk_idle_exp = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk_pending = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (chk_pending) begin
          if (chk_idle_exp) check("idle_gap_busy", 32'(busy), 32'd0);
          else              check("drain_busy", 32'(busy), 32'd1);
          chk_pending = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat actual grant=%0d data=%0h required none", grant_idx, out_data);
          end else begin
            e = exp_q.pop_front();
            $display("beat grant=%0d data=%0h meta=%0h", grant_idx, out_data, out_metadata);
            check("grant", 32'(grant_idx), 32'(e.grant));
            check("data", 32'(out_data), 32'(e.data));
            check("meta", 32'(out_metadata), 32'(e.meta));
            if (e.meta[0]) begin chk_pending = 1'b1; chk_idle_exp = e.idle_after; end
          end
        end
        if (out_valid && !out_ready) begin
          check("stall_req_ready", 32'(req_ready[grant_idx]), 32'd0);
          if (prev_stall) check("stall_data_stable", {12'd0, out_metadata, out_data}, prev_word);
          prev_stall = 1'b1;
          prev_word = {12'd0, out_metadata, out_data};
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Round-robin: two 3-beat scenes per producer, grants alternate 0,1,0,1.
    push_scene(0, 16'h100, 3, -1, 0);
    push_scene(0, 16'h110, 3, -1, 0);
    push_scene(1, 16'h200, 3, -1, 0);
    push_scene(1, 16'h210, 3, -1, 0);
    expect_scene(0, 16'h100, 3, 1'b0);
    expect_scene(1, 16'h200, 3, 1'b0);
    expect_scene(0, 16'h110, 3, 1'b0);
    expect_scene(1, 16'h210, 3, 1'b0);
    wait_drain("round_robin");

    // Lock hold: producer 1 pauses 5 cycles mid-scene while producer 0 waits.
    push_scene(1, 16'h300, 3, 1, 5);
    expect_scene(1, 16'h300, 3, 1'b0);
    wait_grant(1);
    push_scene(0, 16'h310, 3, -1, 0);
    expect_scene(0, 16'h310, 3, 1'b0);
    wait_drain("lock_hold");

    // Truncation: 6-beat scene, 4 forwarded with forced last, then producer 1.
    check("overflow_before_trunc", 32'(overflow), 32'd0);
    push_scene(0, 16'h400, 6, -1, 0);
    expect_scene(0, 16'h400, 4, 1'b1);
    exp_q[$].meta[0] = 1'b1;
    wait_grant(0);
    push_scene(1, 16'h500, 2, -1, 0);
    expect_scene(1, 16'h500, 2, 1'b0);
    wait_drain("truncation");
    check("overflow_after_trunc", 32'(overflow), 32'd1);

    // Backpressure: out_ready low 3 cycles after the first beat.
    push_scene(0, 16'h600, 3, -1, 0);
    expect_scene(0, 16'h600, 3, 1'b0);
    wait_grant(0);
    stall_out = 3;
    wait_drain("backpressure");
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset mid-LOCKED with producer 0 valid.
    hold_out_low = 1'b1;
    push_scene(0, 16'h700, 3, -1, 0);
    wait_grant(0);
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant", 32'(grant_idx), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    src0_q.delete();
    hold_out_low = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

`ifdef SCENE_ARB_STATS_EN
    push_scene(0, 16'h800, 2, -1, 0);
    push_scene(0, 16'h810, 2, -1, 0);
    push_scene(1, 16'h900, 2, -1, 0);
    expect_scene(0, 16'h800, 2, 1'b0);
    expect_scene(1, 16'h900, 2, 1'b0);
    expect_scene(0, 16'h810, 2, 1'b0);
    wait_drain("stats");
    check("scene_count_p0", 32'(scene_count[15:0]), 32'd2);
    check("scene_count_p1", 32'(scene_count[31:16]), 32'd1);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
